// File: rtl/slot_scan_decoder.sv
// ============================================================================
//  Module   : slot_scan_decoder
//  Brief    : Registered one-hot slot select with direct and frame-scan modes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slot_scan_decoder #(
    parameter int SEL_W      = 3,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  nRESET,
    input  logic                  mode,
    input  logic                  enable,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  load,
    input  logic                  step,
    input  logic [SEL_W-1:0]      slot_last,
    output logic [(2**SEL_W)-1:0] out,
    output logic [SEL_W-1:0]      slot,
    output logic                  wrap,
    output logic                  valid
);

    localparam int             c_N        = 2**SEL_W;
    localparam logic [c_N-1:0] c_INACTIVE = {c_N{ACTIVE_LOW}};
    localparam logic [c_N-1:0] c_BIT0     = {{(c_N-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0] r_cnt;
    logic [c_N-1:0]   r_out;
    logic             r_wrap;
    logic             r_valid;

    logic [SEL_W-1:0] w_cnt_next;
    logic             w_wrap_next;
    logic [SEL_W-1:0] w_sel;
    logic [c_N-1:0]   w_dec;

    // Load beats step; >= catches a counter sitting above a lowered frame end.
    always_comb begin
        w_cnt_next  = r_cnt;
        w_wrap_next = 1'b0;
        if (enable && mode) begin
            if (load) begin
                w_cnt_next = sel_in;
            end else if (step) begin
                if (r_cnt >= slot_last) begin
                    w_cnt_next  = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + SEL_W'(1);
                end
            end
        end
    end

    assign w_sel = mode ? w_cnt_next : sel_in;
    assign w_dec = c_INACTIVE ^ (c_BIT0 << w_sel);

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_cnt   <= '0;
            r_out   <= c_INACTIVE;
            r_wrap  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_wrap <= w_wrap_next;
            if (enable) begin
                r_out   <= w_dec;
                r_valid <= 1'b1;
            end else begin
                r_out   <= c_INACTIVE;
                r_valid <= 1'b0;
            end
        end
    end

    assign out   = r_out;
    assign slot  = r_cnt;
    assign wrap  = r_wrap;
    assign valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_slot_scan_decoder.sv
// ============================================================================
//  Module   : tb_slot_scan_decoder
//  Brief    : Directed self-checking bench for slot_scan_decoder (3/AL and 4/AH).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slot_scan_decoder;

    logic        clk = 1'b0;
    logic        nRESET;

    // SEL_W=3, ACTIVE_LOW=1 instance
    logic        mode3, en3, ld3, st3;
    logic [2:0]  sel3, last3;
    logic [7:0]  out3;
    logic [2:0]  slot3;
    logic        wrap3, valid3;

    // SEL_W=4, ACTIVE_LOW=0 instance
    logic        mode4, en4, ld4, st4;
    logic [3:0]  sel4, last4;
    logic [15:0] out4;
    logic [3:0]  slot4;
    logic        wrap4, valid4;

    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    slot_scan_decoder #(.SEL_W(3), .ACTIVE_LOW(1'b1)) u_dut3 (
        .clk(clk), .nRESET(nRESET), .mode(mode3), .enable(en3),
        .sel_in(sel3), .load(ld3), .step(st3), .slot_last(last3),
        .out(out3), .slot(slot3), .wrap(wrap3), .valid(valid3)
    );

    slot_scan_decoder #(.SEL_W(4), .ACTIVE_LOW(1'b0)) u_dut4 (
        .clk(clk), .nRESET(nRESET), .mode(mode4), .enable(en4),
        .sel_in(sel4), .load(ld4), .step(st4), .slot_last(last4),
        .out(out4), .slot(slot4), .wrap(wrap4), .valid(valid4)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected scan sequence with step held, frame 0..5, starting from slot 0
    logic [2:0] c_seq   [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    logic       c_wseq  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] c_oseq  [7] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFE, 8'hFD};

    initial begin
        logic [7:0] exp8;
        nRESET = 1'b0;
        {mode3, en3, ld3, st3} = 4'b0000; sel3 = 3'd0; last3 = 3'd0;
        {mode4, en4, ld4, st4} = 4'b0000; sel4 = 4'd0; last4 = 4'd0;

        // Reset state
        #13;
        check("rst_out3",   16'(out3),   16'h00FF);
        check("rst_valid3", 16'(valid3), 16'h0000);
        check("rst_slot3",  16'(slot3),  16'h0000);
        check("rst_wrap3",  16'(wrap3),  16'h0000);
        check("rst_out4",   out4,        16'h0000);

        // Direct decode
        @(negedge clk);
        nRESET = 1'b1;
        en3 = 1'b1; sel3 = 3'd5;
        tick();
        check("dir5_out",   16'(out3),   16'h00DF);
        check("dir5_valid", 16'(valid3), 16'h0001);
        check("dir5_wrap",  16'(wrap3),  16'h0000);
        for (int i = 0; i < 8; i++) begin
            sel3 = 3'(i);
            tick();
            exp8 = 8'hFF ^ (8'h01 << i);
            check($sformatf("sweep%0d", i), 16'(out3), 16'(exp8));
        end

        // Enable gating
        sel3 = 3'd2;
        tick();
        check("dir2_out", 16'(out3), 16'h00FB);
        en3 = 1'b0;
        tick();
        check("dis_out",   16'(out3),   16'h00FF);
        check("dis_valid", 16'(valid3), 16'h0000);
        check("dis_slot",  16'(slot3),  16'h0000);

        // Scan wrap over frame 0..5
        en3 = 1'b1; mode3 = 1'b1; ld3 = 1'b1; sel3 = 3'd0; last3 = 3'd5;
        tick();
        check("ld0_slot", 16'(slot3), 16'h0000);
        check("ld0_out",  16'(out3),  16'h00FE);
        ld3 = 1'b0; st3 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("scan_slot%0d", i), 16'(slot3), 16'(c_seq[i]));
            check($sformatf("scan_wrap%0d", i), 16'(wrap3), 16'(c_wseq[i]));
            check($sformatf("scan_out%0d", i),  16'(out3),  16'(c_oseq[i]));
        end

        // Load priority and out-of-range wrap
        ld3 = 1'b1; st3 = 1'b1; sel3 = 3'd7; last3 = 3'd4;
        tick();
        check("ldpri_slot", 16'(slot3), 16'h0007);
        check("ldpri_wrap", 16'(wrap3), 16'h0000);
        check("ldpri_out",  16'(out3),  16'h007F);
        ld3 = 1'b0;
        tick();
        check("oor_slot", 16'(slot3), 16'h0000);
        check("oor_wrap", 16'(wrap3), 16'h0001);

        // Disabled while scanning: counter frozen, no wrap
        en3 = 1'b0;
        tick();
        tick();
        check("frz_slot",  16'(slot3),  16'h0000);
        check("frz_wrap",  16'(wrap3),  16'h0000);
        check("frz_valid", 16'(valid3), 16'h0000);
        en3 = 1'b1;

        // Degenerate frame
        last3 = 3'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("deg_slot%0d", i), 16'(slot3), 16'h0000);
            check($sformatf("deg_wrap%0d", i), 16'(wrap3), 16'h0001);
        end
        #2;
        nRESET = 1'b0;
        #1;
        check("arst_out",   16'(out3),   16'h00FF);
        check("arst_wrap",  16'(wrap3),  16'h0000);
        check("arst_valid", 16'(valid3), 16'h0000);
        st3 = 1'b0;
        @(negedge clk);
        nRESET = 1'b1;

        // Counter preserved across mode switch
        ld3 = 1'b1; sel3 = 3'd3;
        tick();
        ld3 = 1'b0; mode3 = 1'b0; sel3 = 3'd6;
        tick();
        check("msw_dir_out",  16'(out3),  16'h00BF);
        check("msw_dir_slot", 16'(slot3), 16'h0003);
        mode3 = 1'b1;
        tick();
        check("msw_scan_out", 16'(out3), 16'h00F7);
        en3 = 1'b0; mode3 = 1'b0;

        // Wide, active-high instance
        en4 = 1'b1; mode4 = 1'b1; ld4 = 1'b1; sel4 = 4'd0; last4 = 4'd15;
        tick();
        check("w_s0_out", out4, 16'h0001);
        sel4 = 4'd14;
        tick();
        check("w_s14_out", out4, 16'h4000);
        ld4 = 1'b0; st4 = 1'b1;
        tick();
        check("w_s15_slot", 16'(slot4), 16'h000F);
        check("w_s15_out",  out4,       16'h8000);
        check("w_s15_wrap", 16'(wrap4), 16'h0000);
        tick();
        check("w_wrap_slot", 16'(slot4), 16'h0000);
        check("w_wrap_out",  out4,       16'h0001);
        check("w_wrap_wrap", 16'(wrap4), 16'h0001);
        tick();
        check("w_s1_slot", 16'(slot4), 16'h0001);
        check("w_s1_wrap", 16'(wrap4), 16'h0000);
        check("w_s1_valid", 16'(valid4), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slot_scan_decoder.md
Name: slot_scan_decoder

Overview:
Parametrised, registered one-hot select generator for the PCM channel/slot datapath. It generalises the 3-to-8 active-low decoder to any select width and adds a scan mode. In scan mode an internal slot counter steps through channels 0..slot_last, raising a wrap pulse at the end of each frame. It sits between the sequencer timing logic and the per-channel register banks, and drives their slot selects.

Parameters:
SEL_W, 3, select/counter width; number of outputs N = 2**SEL_W (derived, not overridable)
ACTIVE_LOW, 1, 1: selected output driven 0 and others 1; 0: selected output 1 and others 0

Ports:
clk  input  1  system clock; all state updates on rising edge
nRESET  input  1  asynchronous active-low reset
mode  input  1  0 = direct decode of sel_in; 1 = scan using the internal counter
enable  input  1  0 forces all outputs inactive and freezes the counter
sel_in  input  SEL_W  index decoded in direct mode; load value in scan mode
load  input  1  scan mode: counter <= sel_in
step  input  1  scan mode: advance counter by one slot
slot_last  input  SEL_W  last slot of the scan frame (inclusive)
out  output  2**SEL_W  registered one-hot select, polarity per ACTIVE_LOW
slot  output  SEL_W  current counter value (registered)
wrap  output  1  one-cycle pulse when the counter wraps to 0
valid  output  1  high when out holds a decoded select (not forced inactive)

Behaviour:
- Reset (nRESET low, asynchronous): counter/slot = 0, out = all inactive (all 1s if ACTIVE_LOW=1, all 0s otherwise), wrap = 0, valid = 0. Release is synchronous to clk; the first decode appears one edge after release.
- INACTIVE = {N{ACTIVE_LOW}}. onehot(i) = INACTIVE with bit i inverted.
- All outputs are registered. Latency from an input change to out/valid is 1 clk.
- enable = 0 (either mode):
  - out <= INACTIVE, valid <= 0, wrap <= 0.
  - Counter holds; load and step are ignored.
- Direct mode (mode = 0, enable = 1):
  - out <= onehot(sel_in), valid <= 1, wrap <= 0.
  - Counter holds; load and step are ignored; slot shows the held counter.
- Scan mode (mode = 1, enable = 1). Next counter value, in priority order:
  1. load = 1: cnt_next = sel_in. Load wins over a simultaneous step; wrap <= 0.
  2. step = 1 and cnt >= slot_last: cnt_next = 0, wrap <= 1. The >= compare covers a counter loaded above slot_last, or slot_last lowered mid-frame.
  3. step = 1 and cnt < slot_last: cnt_next = cnt + 1, wrap <= 0.
  4. Otherwise: cnt_next = cnt, wrap <= 0.
- Scan mode outputs: out <= onehot(cnt_next), slot <= cnt_next, valid <= 1. The select moves in the same cycle the counter updates.
- slot_last = 0 with continuous step: counter stays 0 and wrap is high every stepped cycle.
- slot_last = N-1: full-width wrap from N-1 to 0. No arithmetic overflow is possible because the compare fires first.
- Mode switch: the counter is preserved across mode changes. Entering scan mode with no load/step decodes the held counter on the next edge.
- The wrap pulse is exactly one cycle per wrapping step, and never asserts in direct mode or while disabled.
- Reset mid-scan: immediate return to reset values. No partial pulse on wrap survives.
- out is always one-hot-or-inactive: exactly one active bit when valid = 1, none when valid = 0.
- Implementation: one SEL_W-bit counter, a comparator, the decode, and output registers. No combinational path from inputs to outputs.

Test Plan:
- Reset/direct decode, SEL_W=3, ACTIVE_LOW=1: assert nRESET low, check out = 8'hFF, valid = 0. Release, mode = 0, enable = 1, sel_in = 5. Next edge: out = 8'b11011111, valid = 1. Sweep sel_in 0..7 and check every code.
- Enable gating: direct mode with sel_in = 2, drop enable. Next edge: out = 8'hFF, valid = 0, slot unchanged.
- Scan wrap: mode = 1, load with sel_in = 0, slot_last = 5, step held high. slot sequence is 1,2,3,4,5,0,1. wrap is high only on the edge producing 0. out tracks, e.g. slot = 3 gives out = 8'b11110111.
- Load priority and out-of-range: load = 1, step = 1, sel_in = 7, slot_last = 4. Next edge: slot = 7, wrap = 0. Next step: slot = 0, wrap = 1.
- Degenerate frame: slot_last = 0, step high for 4 cycles. slot stays 0 and wrap is high for all 4 cycles. Then pulse nRESET low mid-sequence: out = 8'hFF and wrap = 0 immediately (asynchronous).
- Parameter sweep: SEL_W=4, ACTIVE_LOW=0, scan with slot_last = 15. Check out = 16'h0001 at slot 0 and 16'h8000 at slot 15, and wrap on the transition 15 to 0.
